// File: rtl/irq_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// irq_input_conditioner_if : raw/config inputs and conditioned/status outputs
// Rev 1.0
// ============================================================================
interface irq_input_conditioner_if #(
  parameter int NUM_IRQ = 8
);
  logic [NUM_IRQ-1:0] irq_raw;
  logic [NUM_IRQ-1:0] irq_en;
  logic [NUM_IRQ-1:0] edge_mode;
  logic [NUM_IRQ-1:0] polarity;
  logic [NUM_IRQ-1:0] glitch_clr;
  logic [NUM_IRQ-1:0] irq_req;
  logic [NUM_IRQ-1:0] irq_filtered;
  logic [NUM_IRQ-1:0] glitch_seen;

  modport master (
    output irq_raw, irq_en, edge_mode, polarity, glitch_clr,
    input  irq_req, irq_filtered, glitch_seen
  );

  modport slave (
    input  irq_raw, irq_en, edge_mode, polarity, glitch_clr,
    output irq_req, irq_filtered, glitch_seen
  );
endinterface
`default_nettype wire

// File: rtl/irq_input_conditioner.sv
`default_nettype none
// ============================================================================
// irq_input_conditioner : sync, polarity fix, stable-count filter, level/edge out
// Rev 1.0
// ============================================================================
module irq_input_conditioner #(
  parameter int NUM_IRQ       = 8,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = $clog2(FILTER_CYCLES + 1)
) (
  input wire logic              clk,
  input wire logic              rst,
  irq_input_conditioner_if.slave bus
);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(FILTER_CYCLES - 1);

  logic [NUM_IRQ-1:0] r_s1;
  logic [NUM_IRQ-1:0] r_s2;
  logic [NUM_IRQ-1:0] w_f;
  logic [NUM_IRQ-1:0] w_f_d;
  logic [NUM_IRQ-1:0] w_glitch;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= bus.irq_raw;
      r_s2 <= r_s1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_line
      logic [CNT_W-1:0] r_cnt;
      logic             r_f;
      logic             r_f_d;
      logic             r_glitch;
      logic             w_a;

      assign w_a = r_s2[gi] ^ bus.polarity[gi];

      // The counter only ever holds a partial run, so it resets on acceptance.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt    <= '0;
          r_f      <= 1'b0;
          r_f_d    <= 1'b0;
          r_glitch <= 1'b0;
        end else begin
          r_f_d    <= r_f;
          r_glitch <= r_glitch & ~bus.glitch_clr[gi];
          if (w_a != r_f) begin
            if (r_cnt == c_cnt_last) begin
              r_f   <= w_a;
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (r_cnt != '0) begin
            r_cnt    <= '0;
            r_glitch <= 1'b1;
          end
        end
      end

      assign w_f[gi]      = r_f;
      assign w_f_d[gi]    = r_f_d;
      assign w_glitch[gi] = r_glitch;
    end
  endgenerate

  // Edge mode qualifies with the previous filtered value to leave a one-cycle pulse.
  assign bus.irq_req      = w_f & bus.irq_en & (~bus.edge_mode | ~w_f_d);
  assign bus.irq_filtered = w_f;
  assign bus.glitch_seen  = w_glitch;
endmodule
`default_nettype wire

// File: tb/tb_irq_input_conditioner.sv
`default_nettype none
// ============================================================================
// tb_irq_input_conditioner : directed + random stimulus against a history model
// Rev 1.0
// ============================================================================
module tb_irq_input_conditioner;
  localparam int N  = 8;
  localparam int FC = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  irq_input_conditioner_if #(.NUM_IRQ(N)) bus ();

  irq_input_conditioner #(.NUM_IRQ(N), .FILTER_CYCLES(FC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks;
  int n_errors;
  bit armed;

  logic [N-1:0] raw_v, en_v, em_v, pol_v, clr_v;
  logic         rst_v;

  // Reference state: accepted level, its previous value, sticky glitch flags,
  // raw-input history (for the two-stage sync) and per-line sample history
  // since the last accepted level.
  logic [N-1:0] m_f, m_fd, m_g;
  logic [N-1:0] raw_q[$];
  bit           samp_q[N][$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] s2_old, new_f, set;
    int run;
    if (rst_v) begin
      m_f = '0; m_fd = '0; m_g = '0;
      raw_q.delete();
      for (int i = 0; i < N; i++) samp_q[i].delete();
      return;
    end
    s2_old = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : '0;
    new_f  = m_f;
    set    = '0;
    for (int i = 0; i < N; i++) begin
      bit a;
      a = s2_old[i] ^ pol_v[i];
      if (a == m_f[i] && samp_q[i].size() > 0 && samp_q[i][samp_q[i].size()-1] != m_f[i])
        set[i] = 1'b1;
      samp_q[i].push_back(a);
      run = 0;
      for (int j = samp_q[i].size() - 1; j >= 0 && samp_q[i][j] != m_f[i]; j--) run++;
      if (run >= FC) begin
        new_f[i] = a;
        samp_q[i].delete();
      end
      while (samp_q[i].size() > FC + 1) void'(samp_q[i].pop_front());
    end
    m_fd = m_f;
    m_f  = new_f;
    m_g  = (m_g & ~clr_v) | set;
    raw_q.push_back(raw_v);
    if (raw_q.size() > 3) void'(raw_q.pop_front());
  endtask

  // Called just after a falling edge: drive, check outputs, clock, advance model.
  task automatic step();
    logic [N-1:0] exp_req;
    bus.irq_raw    = raw_v;
    bus.irq_en     = en_v;
    bus.edge_mode  = em_v;
    bus.polarity   = pol_v;
    bus.glitch_clr = clr_v;
    rst            = rst_v;
    #1;
    if (armed) begin
      for (int i = 0; i < N; i++)
        exp_req[i] = en_v[i] && m_f[i] && (em_v[i] ? !m_fd[i] : 1'b1);
      check_eq("irq_req", bus.irq_req, exp_req);
      check_eq("irq_filtered", bus.irq_filtered, m_f);
      check_eq("glitch_seen", bus.glitch_seen, m_g);
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic glitch_line1(input bit clr_same);
    raw_v[1] = 1'b1; step(); step();
    raw_v[1] = 1'b0; step(); step();
    clr_v[1] = clr_same; step();
    clr_v[1] = 1'b0; step(); step();
  endtask

  initial begin
    int pulses;
    int pos;
    n_checks = 0; n_errors = 0; armed = 1'b0;
    m_f = '0; m_fd = '0; m_g = '0;
    raw_v = '1; en_v = '1; em_v = '0; pol_v = '0; clr_v = '0; rst_v = 1'b1;
    @(negedge clk);
    step(); step();
    armed = 1'b1;
    step();
    check_eq("rst_req", bus.irq_req, 0);
    check_eq("rst_filt", bus.irq_filtered, 0);
    check_eq("rst_glitch", bus.glitch_seen, 0);

    // Release: requests appear FILTER_CYCLES+1 edges after the first free edge.
    rst_v = 1'b0;
    for (int m = 0; m < 8; m++) begin
      step();
      check_eq("rst_release_req", bus.irq_req, (m >= 1 + FC) ? 8'hFF : 8'h00);
    end
    check_eq("rst_release_glitch", bus.glitch_seen, 0);

    // Line 3 edge mode: one pulse on rise, none on fall.
    raw_v[3] = 1'b0;
    for (int m = 0; m < 10; m++) step();
    em_v[3] = 1'b1;
    raw_v[3] = 1'b1;
    pulses = 0; pos = -1;
    for (int m = 0; m < 20; m++) begin
      step();
      if (bus.irq_req[3]) begin pulses++; pos = m; end
    end
    check_eq("edge3_pulses", pulses, 1);
    check_eq("edge3_pos", pos, 1 + FC);
    raw_v[3] = 1'b0;
    pulses = 0;
    for (int m = 0; m < 12; m++) begin
      step();
      if (bus.irq_req[3]) pulses++;
    end
    check_eq("edge3_fall_pulses", pulses, 0);

    // Line 1 glitch, clear, then clear coinciding with a new glitch.
    raw_v[1] = 1'b0;
    for (int m = 0; m < 10; m++) step();
    glitch_line1(1'b0);
    check_eq("glitch1_set", bus.glitch_seen[1], 1);
    check_eq("glitch1_filt", bus.irq_filtered[1], 0);
    clr_v[1] = 1'b1; step(); clr_v[1] = 1'b0;
    check_eq("glitch1_clr", bus.glitch_seen[1], 0);
    glitch_line1(1'b1);
    check_eq("glitch1_clr_race", bus.glitch_seen[1], 1);

    // Line 5 active-low.
    pol_v[5] = 1'b1;
    for (int m = 0; m < 8; m++) step();
    check_eq("pol5_idle", bus.irq_filtered[5], 0);
    raw_v[5] = 1'b0;
    for (int m = 0; m < 6; m++) begin
      step();
      if (m >= 4) check_eq("pol5_filt", bus.irq_filtered[5], (m >= 1 + FC) ? 1 : 0);
    end
    check_eq("pol5_req", bus.irq_req[5], 1);

    // Line 7 enable gating in level mode, then mode switch with f already high.
    en_v[7] = 1'b0; step();
    check_eq("en7_off", bus.irq_req[7], 0);
    en_v[7] = 1'b1; step();
    check_eq("en7_on", bus.irq_req[7], 1);
    em_v[7] = 1'b1;
    pulses = 0;
    for (int m = 0; m < 6; m++) begin
      step();
      if (bus.irq_req[7]) pulses++;
    end
    check_eq("mode7_pulses", pulses, 0);
    em_v[7] = 1'b0;

    // Reset in the middle of a qualifying run on line 0.
    raw_v[0] = 1'b0;
    for (int m = 0; m < 8; m++) step();
    raw_v[0] = 1'b1;
    for (int m = 0; m < 4; m++) step();
    rst_v = 1'b1; step(); rst_v = 1'b0;
    check_eq("midrst_filt", bus.irq_filtered, 0);
    for (int m = 0; m < 8; m++) begin
      step();
      check_eq("midrst_requal", bus.irq_filtered[0], (m >= 1 + FC) ? 1 : 0);
    end

    // Random phase.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(5) == 0) raw_v[i] = ~raw_v[i];
      if ($urandom_range(15) == 0) en_v  = N'($urandom);
      if ($urandom_range(25) == 0) em_v  = N'($urandom);
      if ($urandom_range(40) == 0) pol_v = N'($urandom);
      clr_v = ($urandom_range(7) == 0) ? N'($urandom) : '0;
      rst_v = ($urandom_range(299) == 0);
      step();
    end
    rst_v = 1'b0; clr_v = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
